// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake into the UART transmitter FIFO.
interface uart_tx_if;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    modport master (output data_in, data_valid, input data_ready);
    modport slave  (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx #(
    parameter int CLKS_PER_BIT = 102,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    uart_tx_if.slave                    bus,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [CW-1:0] baud, baud_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n, head;
    logic          tx_n, push, pop, baud_end;
    // Room is judged from registered pointers only, so a same-cycle pop never frees a slot.
    assign fifo_count     = wr_ptr - rd_ptr;
    assign bus.data_ready = fifo_count != (AW+1)'(FIFO_DEPTH);
    assign push           = bus.data_valid && bus.data_ready;
    assign head           = mem[rd_ptr[AW-1:0]];
    assign busy           = state != IDLE;
    assign baud_end       = baud == CW'(CLKS_PER_BIT - 1);
    assign pop            = fifo_count != '0 && (state == IDLE || (state == STOP && baud_end));
    always_ff @(posedge clock)
        if (push) mem[wr_ptr[AW-1:0]] <= bus.data_in;
`ifdef UART_TX_PARITY_EN
    logic par, par_n;
    assign par_n = pop ? ^head : par;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) par <= 1'b0;
        else par <= par_n;
`endif
    always_comb begin
        state_n = state;
        baud_n  = baud_end ? '0 : baud + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        case (state)
            IDLE: begin
                baud_n = '0;
                if (pop) state_n = START;
            end
            START: if (baud_end) begin
                state_n = DATA;
                idx_n   = '0;
            end
            DATA: if (baud_end) begin
                shreg_n = shreg >> 1;
                idx_n   = idx + 1'b1;
`ifdef UART_TX_PARITY_EN
                if (idx == 3'd7) state_n = PARITY;
`else
                if (idx == 3'd7) state_n = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_end) state_n = STOP;
`endif
            STOP: if (baud_end) state_n = pop ? START : IDLE;
            default: state_n = IDLE;
        endcase
        if (pop) shreg_n = head;
        // tx is registered from the next state so it changes cleanly on the edge.
`ifdef UART_TX_PARITY_EN
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : state_n == PARITY ? par_n : 1'b1;
`else
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : 1'b1;
`endif
    end
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state  <= IDLE;
            baud   <= '0;
            idx    <= '0;
            shreg  <= '0;
            tx     <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_n;
            baud   <= baud_n;
            idx    <= idx_n;
            shreg  <= shreg_n;
            tx     <= tx_n;
            wr_ptr <= wr_ptr + (AW+1)'(push);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
        end
endmodule
